// File: rtl/uart_data_manager.sv
// uart_data_manager: 8N1 UART receiver feeding a byte FIFO that echoes every byte back out
module uart_data_manager #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic clk100mhz,
    input  logic cpu_resetn,
    input  logic uart_txd_in,
    output logic uart_rxd_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    rx_state_t rx_state;
    tx_state_t tx_state;
    logic [1:0] sync, prime;
    logic armed, rx_s, rx_done, push, pop, fifo_empty, fifo_full;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic [2:0] rx_idx, tx_idx;
    logic [7:0] rx_sh, tx_sh;
    logic [AW:0] wptr, rptr;
    logic [7:0] mem [FIFO_DEPTH];

    assign rx_s = sync[1];
    assign rx_done = rx_state == R_STOP && rx_cnt == FULL_CNT && rx_s;
    assign pop = tx_state == T_IDLE && !fifo_empty;
    assign push = rx_done && (!fifo_full || pop);
    assign fifo_empty = wptr == rptr;
    assign fifo_full = wptr == {~rptr[AW], rptr[AW-1:0]};

    // prime marks when the synchronizer holds real line samples rather than its reset value
    always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            sync <= 2'b11;
            prime <= 2'b00;
            armed <= 1'b0;
            rx_state <= R_IDLE;
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_sh <= '0;
        end else begin
            sync <= {sync[0], uart_txd_in};
            prime <= {prime[0], 1'b1};
            case (rx_state)
                R_IDLE: if (prime[1]) begin
                    if (rx_s) armed <= 1'b1;
                    else begin
                        rx_cnt <= '0;
                        rx_state <= armed ? R_START : R_WAIT;
                    end
                end
                R_START: if (rx_cnt == HALF_CNT) begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    rx_state <= rx_s ? R_IDLE : R_DATA;
                end else rx_cnt <= rx_cnt + CW'(1);
                R_DATA: if (rx_cnt == FULL_CNT) begin
                    rx_cnt <= '0;
                    rx_sh[rx_idx] <= rx_s;
                    rx_idx <= rx_idx + 3'd1;
                    if (rx_idx == 3'd7) rx_state <= R_STOP;
                end else rx_cnt <= rx_cnt + CW'(1);
                R_STOP: if (rx_cnt == FULL_CNT) begin
                    rx_cnt <= '0;
                    rx_state <= rx_s ? R_IDLE : R_WAIT;
                end else rx_cnt <= rx_cnt + CW'(1);
                R_WAIT: if (rx_s) begin
                    armed <= 1'b1;
                    rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (push) mem[wptr[AW-1:0]] <= rx_sh;
    end

    // the shifter back-fills ones so the bit after d7 is already the stop level
    always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            tx_state <= T_IDLE;
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_sh <= '0;
            uart_rxd_out <= 1'b1;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    uart_rxd_out <= 1'b1;
                    if (!fifo_empty) begin
                        tx_sh <= mem[rptr[AW-1:0]];
                        tx_cnt <= '0;
                        uart_rxd_out <= 1'b0;
                        tx_state <= T_START;
                    end
                end
                T_START: if (tx_cnt == FULL_CNT) begin
                    tx_cnt <= '0;
                    tx_idx <= '0;
                    uart_rxd_out <= tx_sh[0];
                    tx_state <= T_DATA;
                end else tx_cnt <= tx_cnt + CW'(1);
                T_DATA: if (tx_cnt == FULL_CNT) begin
                    tx_cnt <= '0;
                    tx_idx <= tx_idx + 3'd1;
                    tx_sh <= {1'b1, tx_sh[7:1]};
                    uart_rxd_out <= tx_sh[1];
                    if (tx_idx == 3'd7) tx_state <= T_STOP;
                end else tx_cnt <= tx_cnt + CW'(1);
                T_STOP: if (tx_cnt == FULL_CNT) begin
                    tx_cnt <= '0;
                    tx_state <= T_IDLE;
                end else tx_cnt <= tx_cnt + CW'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_uart_data_manager.sv
// tb_uart_data_manager: drives 8N1 frames in and decodes the echoed frames against an expected-byte queue
module tb_uart_data_manager;
    localparam int CPB = 16;
    localparam int HALF = CPB / 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0, rst_n = 1'b0, line = 1'b1, txo;
    int cyc = 0, vecs = 0, errs = 0, frames = 0, fall_cyc = 0, stop_cyc = 0, off = -1;
    bit mon_en = 1'b1, blocked = 1'b0, shape_bad = 1'b0;
    logic [9:0] bits = '0;
    logic [7:0] got, last_byte = '0;
    logic [7:0] exp_q[$];

    uart_data_manager #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk100mhz(clk),
        .cpu_resetn(rst_n),
        .uart_txd_in(line),
        .uart_rxd_out(txo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_high(input int n, input string name);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (txo !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        for (int i = 0; i < budget && frames < target; i++) @(negedge clk);
        check(name, frames, target);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) @(negedge clk);
        end
        line = stop_ok;
        stop_cyc = cyc;
        repeat (CPB) @(negedge clk);
        line = 1'b1;
        if (stop_ok && (!blocked || exp_q.size() < DEPTH)) exp_q.push_back(b);
    endtask

    // decoder: each bit must hold one level for exactly CPB cycles, start low, stop high
    initial forever begin
        @(negedge clk);
        if (!mon_en) off = -1;
        else if (off < 0 && txo === 1'b0) begin
            off = 0;
            fall_cyc = cyc;
            shape_bad = 1'b0;
        end else if (off >= 0) off++;
        if (off >= 0) begin
            if (off % CPB == 0) bits[off / CPB] = txo;
            else if (txo !== bits[off / CPB]) shape_bad = 1'b1;
            if (off == 10 * CPB - 1) begin
                got = bits[8:1];
                last_byte = got;
                frames++;
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL echo_frame: unexpected frame 0x%0h, required no frame", got);
                end else begin
                    if (got !== exp_q[0] || bits[0] !== 1'b0 || bits[9] !== 1'b1 || shape_bad) begin
                        errs++;
                        $display("FAIL echo_frame: got 0x%0h start=%0b stop=%0b glitch=%0b, required 0x%0h start=0 stop=1 glitch=0",
                                 got, bits[0], bits[9], shape_bad, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                off = -1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (txo !== 1'b1) lows++;
        end
        check("reset_line_high", lows, 0);
        rst_n = 1'b1;
        check_high(30 * CPB, "idle_after_reset");
        check("no_frames_after_reset", frames, 0);

        send_byte(8'hA0, 1'b1);
        wait_frames(1, 12 * CPB, "single_frame_count");
        check("echo_latency", int'(fall_cyc - stop_cyc >= HALF + 2 && fall_cyc - stop_cyc <= HALF + 7), 1);
        check("single_byte", last_byte, 8'hA0);

        repeat (20 * CPB) @(negedge clk);
        send_byte(8'hA0, 1'b1);
        repeat (20 * CPB) @(negedge clk);
        send_byte(8'hA0, 1'b1);
        repeat (20 * CPB) @(negedge clk);
        send_byte(8'h30, 1'b1);
        wait_frames(4, 15 * CPB, "repeat_frame_count");
        check("repeat_last_byte", last_byte, 8'h30);

        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b1);
        wait_frames(24, 15 * CPB, "burst_frame_count");
        check("burst_last_byte", last_byte, 8'h13);
        check("burst_drained", exp_q.size(), 0);

        repeat (2 * CPB) @(negedge clk);
        blocked = 1'b1;
        force dut.fifo_empty = 1'b1;
        for (int i = 0; i < 17; i++) send_byte(8'(8'h40 + i), 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("blocked_no_echo", frames, 24);
        check("model_capacity", exp_q.size(), 16);
        release dut.fifo_empty;
        blocked = 1'b0;
        wait_frames(40, 18 * 10 * CPB, "overflow_frame_count");
        check("overflow_last_byte", last_byte, 8'h4F);
        repeat (4 * CPB) @(negedge clk);
        check("overflow_no_extra", frames, 40);

        send_byte(8'h55, 1'b0);
        check_high(15 * CPB, "framing_no_echo");
        send_byte(8'h3C, 1'b1);
        wait_frames(41, 15 * CPB, "after_framing_count");
        check("after_framing_byte", last_byte, 8'h3C);

        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        check_high(15 * CPB, "false_start_no_echo");
        check("false_start_frames", frames, 41);

        send_byte(8'h21, 1'b1);
        for (int i = 0; i < 12 * CPB && off < 4 * CPB + HALF; i++) @(negedge clk);
        check("mid_echo_bit3", txo, 0);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_forces_high", txo, 1);
        exp_q.delete();
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        check_high(20 * CPB, "no_bits_after_reset");
        check("reset_abort_frames", frames, 41);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
